// File: rtl/mem_stage_lsu_if.sv
// Data memory port driven by the MEM-stage LSU: word-indexed, synchronous read.
// master = LSU (address/write side), slave = data memory.
interface mem_stage_lsu_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] MemAddr;
   logic [31:0]       MemWData;
   logic              MemWE;
   logic [31:0]       MemRData;

   modport master (output MemAddr, output MemWData, output MemWE, input MemRData);
   modport slave  (input MemAddr, input MemWData, input MemWE, output MemRData);
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store initiator: word stores, stalled loads, sub-word stores by read-modify-write.
// Define LSU_SUBWORD_EN to build byte/halfword support (RMW_MERGE state, lane select, sign/zero extension).
//
// state     | meaning
// IDLE      | accept a request; word stores complete here in one cycle
// LOAD_WAIT | memory read data valid; format it and register into ReadDataW
// RMW_MERGE | merge latched sub-word store data into read word and write back
module mem_stage_lsu #(
   parameter int ADDR_W = 8
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            MemReadM,
   input  logic            MemWriteM,
   input  logic [31:0]     ALUResultM,
   input  logic [31:0]     WriteDataM,
   input  logic [1:0]      SizeM,
   input  logic            LoadSignedM,
   mem_stage_lsu_if.master mem,
   output logic [31:0]     ReadDataW,
   output logic            LoadValidW,
   output logic            StallM,
   output logic            MisalignM
);

`ifdef LSU_SUBWORD_EN
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD_WAIT = 2'd1, RMW_MERGE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD_WAIT = 2'd1} state_t;
`endif

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] idx, idx_q;
   logic [1:0]        lane;
   logic              req, misalign, is_word;
   logic [31:0]       load_fmt;
   logic              unused_bits;

   // Upper address bits are dropped so accesses wrap modulo memory depth.
   assign idx  = ALUResultM[ADDR_W+1:2];
   assign lane = ALUResultM[1:0];
   assign req  = MemReadM | MemWriteM;

`ifdef LSU_SUBWORD_EN
   logic [4:0]  sh, sh_q;
   logic [1:0]  size_q;
   logic        sign_q;
   logic [31:0] wmask, wmask_q, wdata_q, lane_data, merged;

   assign is_word     = SizeM[1];
   assign sh          = {lane, 3'b000};
   assign wmask       = ((SizeM == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
   assign merged      = (mem.MemRData & ~wmask_q) | wdata_q;
   assign unused_bits = ^ALUResultM[31:ADDR_W+2];

   always_comb begin
      case (SizeM)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = lane[0];
         default: misalign = |lane;
      endcase
   end

   // Word accesses are aligned, so sh_q is zero and lane_data is the raw word.
   always_comb begin
      lane_data = mem.MemRData >> sh_q;
      case (size_q)
         2'b00:   load_fmt = {{24{sign_q & lane_data[7]}}, lane_data[7:0]};
         2'b01:   load_fmt = {{16{sign_q & lane_data[15]}}, lane_data[15:0]};
         default: load_fmt = lane_data;
      endcase
   end
`else
   assign is_word     = 1'b1;
   assign misalign    = |lane;
   assign load_fmt    = mem.MemRData;
   assign unused_bits = ^{ALUResultM[31:ADDR_W+2], SizeM, LoadSignedM};
`endif

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req && !misalign) begin
`ifdef LSU_SUBWORD_EN
               if (MemWriteM) state_nxt = is_word ? IDLE : RMW_MERGE;
`else
               if (MemWriteM) state_nxt = IDLE;
`endif
               else           state_nxt = LOAD_WAIT;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem.MemAddr  = idx;
      mem.MemWData = WriteDataM;
      mem.MemWE    = 1'b0;
      StallM       = 1'b0;
      MisalignM    = 1'b0;
      case (state)
         IDLE: begin
            if (req && !RST) begin
               MisalignM = misalign;
               if (!misalign) begin
                  if (MemWriteM && is_word) mem.MemWE = 1'b1;
                  else                      StallM    = 1'b1;
               end
            end
         end
         LOAD_WAIT: mem.MemAddr = idx_q;
`ifdef LSU_SUBWORD_EN
         RMW_MERGE: begin
            mem.MemAddr  = idx_q;
            mem.MemWData = merged;
            mem.MemWE    = !RST;
         end
`endif
         default: ;
      endcase
   end

   // Request fields are captured every IDLE cycle; only the accepted one is ever used.
   always_ff @(posedge CLK) begin
      if (state == IDLE) begin
         idx_q   <= idx;
`ifdef LSU_SUBWORD_EN
         sh_q    <= sh;
         size_q  <= SizeM;
         sign_q  <= LoadSignedM;
         wmask_q <= wmask;
         wdata_q <= (WriteDataM << sh) & wmask;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ReadDataW  <= 32'h0;
         LoadValidW <= 1'b0;
      end else begin
         LoadValidW <= (state == LOAD_WAIT);
         if (state == LOAD_WAIT) ReadDataW <= load_fmt;
      end
   end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store initiator for the MEM stage of the MIPS pipeline. It converts pipeline load/store requests into accesses on the word-addressed, synchronous-read data memory port. It also implements byte/halfword stores by read-modify-write, formats loaded data for writeback, and stalls the pipeline while multi-cycle accesses are in flight.

## Interface
- ADDR_W, 8, data memory word-index width (256 words)
- CLK  in  1  clock, all state updates on posedge
- RST  in  1  synchronous, active-high reset
- MemReadM  in  1  load request this cycle
- MemWriteM  in  1  store request this cycle
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, right-aligned
- SizeM  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- LoadSignedM  in  1  sign-extend sub-word load when 1, else zero-extend
- MemAddr  out  ADDR_W  word index to data memory
- MemWData  out  32  write data to data memory
- MemWE  out  1  write enable to data memory
- MemRData  in  32  memory read data, valid the cycle after a non-write address cycle
- ReadDataW  out  32  formatted load result, registered
- LoadValidW  out  1  one-cycle pulse with ReadDataW
- StallM  out  1  hold MEM-stage request and all earlier stages
- MisalignM  out  1  combinational misaligned-access flag, request cycle only

## Operation
- Word index is ALUResultM[ADDR_W+1:2]. Upper address bits are ignored, so accesses wrap modulo depth. Lane is ALUResultM[1:0], little-endian: lane 0 is bits 7:0.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - A misaligned request raises MisalignM, is dropped (no MemWE, no LoadValidW, no stall), and the FSM stays IDLE.
- If MemReadM and MemWriteM are both high, the request is a store. The load is ignored.
- FSM states: IDLE, LOAD_WAIT, RMW_MERGE.
  - IDLE, aligned word store: MemWE=1 and MemWData=WriteDataM in the same cycle. StallM=0. Stay IDLE.
  - IDLE, aligned load: drive MemAddr with MemWE=0. Latch lane, size and sign. StallM=1. Go to LOAD_WAIT.
  - IDLE, aligned sub-word store: drive MemAddr with MemWE=0 (read). Latch index, lane, size and shifted store data. StallM=1. Go to RMW_MERGE.
  - LOAD_WAIT: select lane from MemRData, then extend per latched size/sign. Register the result into ReadDataW with LoadValidW=1 at the clock edge. StallM=0. Go to IDLE. Request inputs are ignored in this state.
  - RMW_MERGE: MemAddr is the latched index. MemWData is MemRData with the target byte(s) replaced. MemWE=1, StallM=0. Go to IDLE. Request inputs are ignored.
- In IDLE with no request, MemAddr follows ALUResultM and MemWE=0. The resulting read is harmless.
- ReadDataW holds its last value between loads. LoadValidW is high for exactly one cycle per load.

## Timing
- Reset values: FSM=IDLE, ReadDataW=0, LoadValidW=0. MemWE, StallM and MisalignM are 0 while RST=1.
- Latencies:
  - Word store: 1 cycle, no stall.
  - Sub-word store: 2 cycles (read, merge-write), StallM high in the first.
  - Load: issued cycle C0 (StallM=1), data taken from memory in C1, ReadDataW/LoadValidW visible in C2.
- Back-to-back: a new request is accepted in the cycle after LOAD_WAIT or RMW_MERGE. There is no dead cycle beyond that.
- Reset mid-operation: the pending RMW is aborted with no write, and a pending load produces no LoadValidW.
- MemWE and MemAddr are combinational from the FSM state and latched or request fields. The memory samples them at the posedge.

## Configuration
- LSU_SUBWORD_EN defined: byte/halfword loads and stores, the RMW_MERGE state, and sign/zero extension are all present, as described above.
- LSU_SUBWORD_EN undefined:
  - SizeM and LoadSignedM are ignored, and every access is a word access.
  - RMW_MERGE is not built, and stores are always single-cycle.
  - Loads return MemRData unmodified.
  - MisalignM checks only addr[1:0]!=0.

## Test plan
- Word store: WriteDataM=0xDEADBEEF, addr 0x10 → MemWE=1 at index 4 in the same cycle, StallM=0. A later word load from 0x10 → ReadDataW=0xDEADBEEF, LoadValidW pulsed 2 cycles after issue.
- Byte store RMW: memory word 4 = 0x11223344, store byte 0xAA at addr 0x12 → 1 stall cycle, then a write of 0x11AA3344.
- Signed loads from 0x80FF7F01 at index 0:
  - Byte at addr 2, signed → 0xFFFFFFFF.
  - Byte at addr 2, unsigned → 0x000000FF.
  - Halfword at addr 2, signed → 0xFFFF80FF.
- Misalign: halfword load at 0x21 or word store at 0x22 → MisalignM=1, no MemWE, no LoadValidW, StallM=0.
- Reset during RMW_MERGE: RST=1 in the merge cycle → no write, the memory word is unchanged, and the FSM is IDLE.
- Wraparound and priority: word store to 0x400 with ADDR_W=8 → index 0. MemReadM=MemWriteM=1 → store only, no LoadValidW.
